// File: rtl/mulaw_pkg.sv
// rtl/mulaw_pkg.sv - Mu-law geometry config, G.711 defaults and derived-constant helpers
package mulaw_pkg;

  typedef struct packed {
    int P_DECODED_DW;
    int P_ENCODED_DW;
    int P_SIGN;
    int P_NUM_CHORD;
    int P_DATA_GOOD;
  } mu_law_t;

  localparam mu_law_t parameter_mu_law_g711_t = '{
    P_DECODED_DW: 14,
    P_ENCODED_DW: 8,
    P_SIGN:       1,
    P_NUM_CHORD:  8,
    P_DATA_GOOD:  4
  };

  // Codeword layout shared with the decoder (G.711 geometry).
  typedef struct packed {
    logic       sign;
    logic [2:0] chord;
    logic [3:0] mant;
  } mulaw_encoded_data;

  function automatic int mulaw_t_dw(input mu_law_t c);
    return c.P_DECODED_DW - c.P_SIGN;
  endfunction

  function automatic int mulaw_bias(input mu_law_t c);
    return (1 << (c.P_DATA_GOOD + 1)) + 1;
  endfunction

  function automatic int mulaw_clip(input mu_law_t c);
    return (1 << mulaw_t_dw(c)) - 1 - mulaw_bias(c);
  endfunction

endpackage

// File: rtl/mulaw_chord_find.sv
// rtl/mulaw_chord_find.sv - combinational leading-one priority encoder for chord selection
module mulaw_chord_find #(
  parameter int P_IN_DW  = 8,
  parameter int P_OUT_DW = 3
) (
  input  logic [P_IN_DW-1:0]  i_bits,
  output logic [P_OUT_DW-1:0] o_idx
);

  // Ascending scan: the highest set bit is the last to overwrite the index.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < P_IN_DW; i++) begin
      if (i_bits[i]) o_idx = P_OUT_DW'(i);
    end
  end

endmodule

// File: rtl/mulaw_enc.sv
// rtl/mulaw_enc.sv - pipelined Mu-law encoder, one sample per clock, 4-cycle fixed latency
// Optional clipped-sample counter on o_sat_cnt: define MULAW_ENC_SAT_CNT_EN.
module mulaw_enc
  import mulaw_pkg::*;
#(
  parameter mu_law_t cfg_t        = parameter_mu_law_g711_t,
  parameter int      P_SAT_CNT_DW = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [cfg_t.P_DECODED_DW-1:0] i_dt,
  input  logic                          i_enable,
  output logic [cfg_t.P_ENCODED_DW-1:0] o_dt,
`ifdef MULAW_ENC_SAT_CNT_EN
  output logic [P_SAT_CNT_DW-1:0]       o_sat_cnt,
`endif
  output logic                          o_enable
);

  localparam int DW   = cfg_t.P_DECODED_DW;
  localparam int EW   = cfg_t.P_ENCODED_DW;
  localparam int T    = mulaw_t_dw(cfg_t);
  localparam int G    = cfg_t.P_DATA_GOOD;
  localparam int CW   = $clog2(cfg_t.P_NUM_CHORD);
  localparam int FW   = T - G - 1;
  localparam int BIAS = mulaw_bias(cfg_t);
  localparam int CLIP = mulaw_clip(cfg_t);

  typedef struct packed {
    logic         sign;
    logic [T-1:0] biased;
  } s1_t;

  logic [3:0]    en_q;
  logic [DW-1:0] x0_q;
  logic [DW-1:0] mag;
  logic          clip_hit;
  logic [T-1:0]  mag_clipped;
  s1_t           s1_d, s1_q;
  logic [CW-1:0] chord_d, s2_chord_q;
  logic          s2_sign_q;
  logic [T-1:0]  s2_biased_q;
  logic [G-1:0]  mant_d;
  logic [EW-1:0] o_dt_d, o_dt_q;

  // Negating -2^T in DW bits yields 2^T as unsigned, which the clip then absorbs.
  always_comb begin
    mag         = x0_q[DW-1] ? (~x0_q + DW'(1)) : x0_q;
    clip_hit    = (mag > DW'(CLIP));
    mag_clipped = clip_hit ? T'(CLIP) : mag[T-1:0];
    s1_d.sign   = x0_q[DW-1];
    s1_d.biased = mag_clipped + T'(BIAS);
  end

  mulaw_chord_find #(
    .P_IN_DW (FW),
    .P_OUT_DW(CW)
  ) u_chord_find (
    .i_bits(s1_q.biased[T-1:G+1]),
    .o_idx (chord_d)
  );

  always_comb begin
    mant_d = G'(s2_biased_q >> (int'(s2_chord_q) + 1));
    o_dt_d = {~s2_sign_q, ~{s2_chord_q, mant_d}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      en_q        <= '0;
      x0_q        <= '0;
      s1_q        <= '0;
      s2_sign_q   <= 1'b0;
      s2_chord_q  <= '0;
      s2_biased_q <= '0;
      o_dt_q      <= '1;
    end else begin
      en_q <= {en_q[2:0], i_enable};
      if (i_enable) x0_q <= i_dt;
      if (en_q[0])  s1_q <= s1_d;
      if (en_q[1]) begin
        s2_sign_q   <= s1_q.sign;
        s2_chord_q  <= chord_d;
        s2_biased_q <= s1_q.biased;
      end
      if (en_q[2])  o_dt_q <= o_dt_d;
    end
  end

  assign o_dt     = o_dt_q;
  assign o_enable = en_q[3];

`ifdef MULAW_ENC_SAT_CNT_EN
  logic [P_SAT_CNT_DW-1:0] sat_cnt_d, sat_cnt_q;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (en_q[0] && clip_hit && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + P_SAT_CNT_DW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) sat_cnt_q <= '0;
    else       sat_cnt_q <= sat_cnt_d;
  end

  assign o_sat_cnt = sat_cnt_q;
`endif

`ifndef SV_ASSERTION_OFF
  if (EW != cfg_t.P_SIGN + CW + G) begin : g_chk_ew
    $error("mulaw_enc: P_ENCODED_DW must equal P_SIGN + clog2(P_NUM_CHORD) + P_DATA_GOOD");
  end
  if (T < cfg_t.P_NUM_CHORD + G) begin : g_chk_t
    $error("mulaw_enc: magnitude width too small for P_NUM_CHORD + P_DATA_GOOD");
  end
  if (P_SAT_CNT_DW < 1) begin : g_chk_sat
    $error("mulaw_enc: P_SAT_CNT_DW must be at least 1");
  end
`endif

endmodule

// File: tb/tb_mulaw_enc.sv
// tb/tb_mulaw_enc.sv - directed self-checking bench for mulaw_enc (G.711 geometry)
module tb_mulaw_enc;
  import mulaw_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [13:0] i_dt = '0;
  logic        i_enable = 1'b0;
  logic [7:0]  o_dt;
  logic        o_enable;
`ifdef MULAW_ENC_SAT_CNT_EN
  logic [1:0]  o_sat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  mulaw_enc #(
`ifdef MULAW_ENC_SAT_CNT_EN
    .P_SAT_CNT_DW(2)
`endif
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_dt    (i_dt),
    .i_enable(i_enable),
    .o_dt    (o_dt),
`ifdef MULAW_ENC_SAT_CNT_EN
    .o_sat_cnt(o_sat_cnt),
`endif
    .o_enable(o_enable)
  );

  // Segment-table formulation of the G.711 14-bit compressor.
  function automatic logic [7:0] ref_ulaw(input int x);
    int ends [8];
    int mag;
    int seg;
    logic [6:0] code;
    ends = '{63, 127, 255, 511, 1023, 2047, 4095, 8191};
    mag = (x < 0) ? -x : x;
    if (mag > 8158) mag = 8158;
    mag = mag + 33;
    seg = 0;
    for (int s = 0; s < 8; s++) if (mag > ends[s]) seg = s + 1;
    code = 7'((seg << 4) | ((mag >> (seg + 1)) & 15));
    return (x < 0) ? {1'b0, ~code} : {1'b1, ~code};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1; i_enable = 1'b0; i_dt = '0;
    repeat (3) @(negedge i_clk);
    total++; if (o_enable !== 1'b0) begin bad++; $display("FAIL reset_enable: got %b want 0", o_enable); end
    total++; if (o_dt !== 8'hFF) begin bad++; $display("FAIL reset_dt: got %h want ff", o_dt); end
`ifdef MULAW_ENC_SAT_CNT_EN
    total++; if (o_sat_cnt !== 2'd0) begin bad++; $display("FAIL reset_sat: got %0d want 0", o_sat_cnt); end
`endif
    i_rst = 1'b0;
  endtask

  task automatic test_single_zero();
    @(negedge i_clk); i_enable = 1'b1; i_dt = 14'd0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge i_clk); i_enable = 1'b0;
      total++;
      if (o_enable !== (i == 4)) begin bad++; $display("FAIL zero_latency cyc%0d: got %b want %b", i, o_enable, (i == 4)); end
    end
    total++; if (o_dt !== 8'hFF) begin bad++; $display("FAIL zero_code: got %h want ff", o_dt); end
  endtask

  task automatic test_back_to_back();
    logic [13:0] st [4];
    logic [7:0]  ex [4];
    st = '{14'd8191, 14'(-8192), 14'd100, 14'(-1)};
    ex = '{8'h80, 8'h00, 8'hDF, 8'h7E};
    for (int i = 0; i < 9; i++) begin
      @(negedge i_clk);
      if (i >= 4 && i < 8) begin
        total++; if (o_enable !== 1'b1) begin bad++; $display("FAIL b2b_en%0d: got %b want 1", i - 4, o_enable); end
        total++; if (o_dt !== ex[i-4]) begin bad++; $display("FAIL b2b_dt%0d: got %h want %h", i - 4, o_dt, ex[i-4]); end
      end else if (i == 8) begin
        total++; if (o_enable !== 1'b0) begin bad++; $display("FAIL b2b_tail: got %b want 0", o_enable); end
      end
      if (i < 4) begin i_enable = 1'b1; i_dt = st[i]; end
      else       begin i_enable = 1'b0; i_dt = '0; end
    end
  endtask

  task automatic test_boundary();
    logic [13:0] st [9];
    logic [7:0]  ex [9];
    st = '{14'd30, 14'd31, 14'(-100), 14'd1000, 14'd4000, 14'(-8191), 14'd8158, 14'd8159, 14'(-31)};
    ex = '{8'hF0, 8'hEF, 8'h5F, 8'hAF, 8'h90, 8'h00, 8'h80, 8'h80, 8'h6F};
    for (int i = 0; i < 13; i++) begin
      @(negedge i_clk);
      if (i >= 4) begin
        total++;
        if (o_enable !== 1'b1 || o_dt !== ex[i-4]) begin
          bad++; $display("FAIL boundary%0d: got en=%b dt=%h want en=1 dt=%h", i - 4, o_enable, o_dt, ex[i-4]);
        end
      end
      if (i < 9) begin i_enable = 1'b1; i_dt = st[i]; end
      else       begin i_enable = 1'b0; i_dt = '0; end
    end
  endtask

  task automatic test_gaps();
    logic        en [5];
    logic [13:0] st [5];
    logic [7:0]  ex [5];
    en = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    st = '{14'd31, 14'd1000, 14'd30, 14'd100, 14'd4000};
    ex = '{8'hEF, 8'hEF, 8'hF0, 8'hDF, 8'hDF};
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (i >= 4 && i < 9) begin
        total++; if (o_enable !== en[i-4]) begin bad++; $display("FAIL gap_en%0d: got %b want %b", i - 4, o_enable, en[i-4]); end
        total++; if (o_dt !== ex[i-4]) begin bad++; $display("FAIL gap_dt%0d: got %h want %h", i - 4, o_dt, ex[i-4]); end
      end
      if (i < 5) begin i_enable = en[i]; i_dt = st[i]; end
      else       begin i_enable = 1'b0; i_dt = '0; end
    end
  endtask

  task automatic test_reset_midstream();
    logic [13:0] st [3];
    st = '{14'd1000, 14'(-100), 14'd4000};
    for (int i = 0; i < 9; i++) begin
      @(negedge i_clk);
      if (i >= 4) begin
        total++;
        if (o_enable !== 1'b0 || o_dt !== 8'hFF) begin
          bad++; $display("FAIL midrst%0d: got en=%b dt=%h want en=0 dt=ff", i, o_enable, o_dt);
        end
      end
      i_rst    = (i == 3);
      i_enable = (i < 3);
      i_dt     = (i < 3) ? st[i] : 14'd0;
    end
    i_enable = 1'b1; i_dt = 14'(-1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge i_clk); i_enable = 1'b0;
      total++;
      if (o_enable !== (i == 4)) begin bad++; $display("FAIL postrst_en cyc%0d: got %b want %b", i, o_enable, (i == 4)); end
    end
    total++; if (o_dt !== 8'h7E) begin bad++; $display("FAIL postrst_dt: got %h want 7e", o_dt); end
  endtask

  task automatic test_sweep();
    localparam int N = 444;
    int v;
    for (int i = 0; i < N + 4; i++) begin
      @(negedge i_clk);
      if (i >= 4) begin
        v = (i - 4 == N - 1) ? 8191 : -8192 + 37 * (i - 4);
        total++;
        if (o_enable !== 1'b1 || o_dt !== ref_ulaw(v)) begin
          bad++; $display("FAIL sweep x=%0d: got en=%b dt=%h want en=1 dt=%h", v, o_enable, o_dt, ref_ulaw(v));
        end
      end
      if (i < N) begin
        v = (i == N - 1) ? 8191 : -8192 + 37 * i;
        i_enable = 1'b1; i_dt = 14'(v);
      end else begin
        i_enable = 1'b0; i_dt = '0;
      end
    end
  endtask

`ifdef MULAW_ENC_SAT_CNT_EN
  task automatic test_sat_cnt();
    logic [1:0] want;
    @(negedge i_clk); i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
    total++; if (o_sat_cnt !== 2'd0) begin bad++; $display("FAIL sat_start: got %0d want 0", o_sat_cnt); end
    for (int k = 0; k < 6; k++) begin
      i_enable = 1'b1; i_dt = (k < 5) ? 14'd8180 : 14'd100;
      @(negedge i_clk); i_enable = 1'b0;
      repeat (3) @(negedge i_clk);
      want = (k >= 2) ? 2'd3 : 2'(k + 1);
      total++; if (o_sat_cnt !== want) begin bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, o_sat_cnt, want); end
    end
    i_rst = 1'b1;
    @(negedge i_clk); i_rst = 1'b0;
    total++; if (o_sat_cnt !== 2'd0) begin bad++; $display("FAIL sat_reset: got %0d want 0", o_sat_cnt); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_zero();
    test_back_to_back();
    test_boundary();
    test_gaps();
    test_reset_midstream();
    test_sweep();
`ifdef MULAW_ENC_SAT_CNT_EN
    test_sat_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
